// File: rtl/monitoreo_pkg.sv
// Shared types and zone classification for the multichannel temperature monitor.
// Per-channel state encoding and sample-zone classification used by every channel.
package monitoreo_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        FRIO   = 2'b01,
        CALOR  = 2'b10
    } estado_t;

    typedef enum logic [1:0] {
        ZONA_NORMAL = 2'b00,
        ZONA_FRIO   = 2'b01,
        ZONA_CALOR  = 2'b10
    } zona_t;

    // Signed compare; both thresholds themselves belong to the normal zone.
    function automatic zona_t clasificar_zona(input int temp, input int bajo, input int alto);
        if (temp < bajo)
            return ZONA_FRIO;
        else if (temp > alto)
            return ZONA_CALOR;
        else
            return ZONA_NORMAL;
    endfunction

    function automatic estado_t zona_a_estado(input zona_t zona);
        case (zona)
            ZONA_FRIO:  return FRIO;
            ZONA_CALOR: return CALOR;
            default:    return NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/monitoreo_canal.sv
// Single-channel monitor: zone persistence counter, NORMAL/FRIO/CALOR FSM, registered actuator decode.
// Build option MON_HISTERESIS_EN adds an exit margin of HISTERESIS around both thresholds.
module monitoreo_canal
    import monitoreo_pkg::*;
#(
    parameter int ANCHO_TEMP   = 11,
    parameter int UMBRAL_BAJO  = 180,
    parameter int UMBRAL_ALTO  = 259,
    parameter int PERSISTENCIA = 6,
    parameter int HISTERESIS   = 10
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic signed [ANCHO_TEMP-1:0] temp,
    input  logic                         valida,
    output logic                         alerta,
    output logic                         ventilador,
    output logic                         calefactor,
    output estado_t                      estado
);

    localparam int CW = $clog2(PERSISTENCIA + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERSISTENCIA);
    localparam logic signed [ANCHO_TEMP:0] SALIDA_FRIO  = (ANCHO_TEMP+1)'(UMBRAL_BAJO + HISTERESIS);
    localparam logic signed [ANCHO_TEMP:0] SALIDA_CALOR = (ANCHO_TEMP+1)'(UMBRAL_ALTO - HISTERESIS);

    logic [CW-1:0] cnt, cnt_n;
    zona_t         zona, zona_mem, zona_mem_n;
    estado_t       est_n;
    logic          salida_frio, salida_calor, retener;

`ifdef MON_HISTERESIS_EN
    logic signed [ANCHO_TEMP:0] temp_ext;
    assign temp_ext     = (ANCHO_TEMP+1)'(temp);
    assign salida_frio  = (temp_ext >= SALIDA_FRIO);
    assign salida_calor = (temp_ext <= SALIDA_CALOR);
`else
    logic unused_hist;
    assign unused_hist  = ^{SALIDA_FRIO, SALIDA_CALOR};
    assign salida_frio  = 1'b1;
    assign salida_calor = 1'b1;
`endif

    assign zona = clasificar_zona(int'(temp), UMBRAL_BAJO, UMBRAL_ALTO);

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        est_n      = estado;
        cnt_n      = cnt;
        zona_mem_n = zona_mem;
        retener    = 1'b0;
        if (valida) begin
            if (zona == ZONA_NORMAL) begin
                retener = (estado == FRIO && !salida_frio) || (estado == CALOR && !salida_calor);
                if (!retener) begin
                    cnt_n = '0;
                    est_n = NORMAL;
                end
            end else begin
                if (cnt != '0 && zona == zona_mem) begin
                    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                end else begin
                    cnt_n      = {{(CW-1){1'b0}}, 1'b1};
                    zona_mem_n = zona;
                end
                // An opposite-zone sample never jumps directly; it passes through NORMAL.
                case (estado)
                    NORMAL:  if (cnt_n == CNT_MAX) est_n = zona_a_estado(zona);
                    FRIO:    if (zona == ZONA_CALOR) est_n = NORMAL;
                    CALOR:   if (zona == ZONA_FRIO) est_n = NORMAL;
                    default: est_n = NORMAL;
                endcase
            end
        end
        if (!(est_n inside {NORMAL, FRIO, CALOR}))
            est_n = NORMAL;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado     <= NORMAL;
            cnt        <= '0;
            zona_mem   <= ZONA_NORMAL;
            alerta     <= 1'b0;
            ventilador <= 1'b0;
            calefactor <= 1'b0;
        end else begin
            estado     <= est_n;
            cnt        <= cnt_n;
            zona_mem   <= zona_mem_n;
            alerta     <= (est_n == FRIO) || (est_n == CALOR);
            ventilador <= (est_n == CALOR);
            calefactor <= (est_n == FRIO);
        end
    end

endmodule

// File: rtl/monitoreo_multicanal.sv
// N-channel temperature monitor: per-channel FSMs plus global alert and lowest-alert-index aggregation.
// Optional build macro MON_HISTERESIS_EN is consumed by monitoreo_canal.
module monitoreo_multicanal
    import monitoreo_pkg::*;
#(
    parameter int N_CANALES    = 4,
    parameter int ANCHO_TEMP   = 11,
    parameter int UMBRAL_BAJO  = 180,
    parameter int UMBRAL_ALTO  = 259,
    parameter int PERSISTENCIA = 6,
    parameter int HISTERESIS   = 10,
    localparam int IDX_W       = (N_CANALES > 1) ? $clog2(N_CANALES) : 1
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic [N_CANALES*ANCHO_TEMP-1:0] temp_entrada,
    input  logic [N_CANALES-1:0]            muestra_valida,
    output logic [N_CANALES-1:0]            alerta,
    output logic [N_CANALES-1:0]            ventilador,
    output logic [N_CANALES-1:0]            calefactor,
    output logic [2*N_CANALES-1:0]          estado_actual,
    output logic                            alerta_global,
    output logic [IDX_W-1:0]                canal_alerta_idx
);

    for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
        estado_t est_canal;

        monitoreo_canal #(
            .ANCHO_TEMP   (ANCHO_TEMP),
            .UMBRAL_BAJO  (UMBRAL_BAJO),
            .UMBRAL_ALTO  (UMBRAL_ALTO),
            .PERSISTENCIA (PERSISTENCIA),
            .HISTERESIS   (HISTERESIS)
        ) u_canal (
            .clk        (clk),
            .arst_n     (arst_n),
            .temp       (signed'(temp_entrada[i*ANCHO_TEMP +: ANCHO_TEMP])),
            .valida     (muestra_valida[i]),
            .alerta     (alerta[i]),
            .ventilador (ventilador[i]),
            .calefactor (calefactor[i]),
            .estado     (est_canal)
        );

        assign estado_actual[2*i +: 2] = est_canal;
    end

    assign alerta_global = |alerta;

    // Scan from the top down so the lowest alerting index wins.
    always_comb begin
        canal_alerta_idx = '0;
        for (int i = N_CANALES - 1; i >= 0; i--) begin
            if (alerta[i])
                canal_alerta_idx = IDX_W'(i);
        end
    end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Directed self-checking bench for monitoreo_multicanal (default parameters, 4 channels).
// Covers reset, persistence, valid gating, threshold boundaries, aggregation and exit hysteresis.
module tb_monitoreo_multicanal;

    logic               clk = 1'b0;
    logic               arst_n;
    logic signed [10:0] t [4];
    logic [3:0]         v;
    logic [43:0]        temp_entrada;
    logic [3:0]         alerta, ventilador, calefactor;
    logic [7:0]         estado_actual;
    logic               alerta_global;
    logic [1:0]         canal_alerta_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign temp_entrada = {t[3], t[2], t[1], t[0]};

    monitoreo_multicanal dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .temp_entrada     (temp_entrada),
        .muestra_valida   (v),
        .alerta           (alerta),
        .ventilador       (ventilador),
        .calefactor       (calefactor),
        .estado_actual    (estado_actual),
        .alerta_global    (alerta_global),
        .canal_alerta_idx (canal_alerta_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int ch, input logic signed [10:0] val, input int n);
        t[ch] = val;
        v[ch] = 1'b1;
        repeat (n) tick();
        v[ch] = 1'b0;
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_alerta"}, 32'(alerta), 32'h0);
        check({tag, "_estado"}, 32'(estado_actual), 32'h0);
        check({tag, "_act"}, 32'({ventilador, calefactor}), 32'h0);
        check({tag, "_glob_idx"}, 32'({alerta_global, canal_alerta_idx}), 32'h0);
    endtask

    initial begin
        arst_n = 1'b0;
        v      = '0;
        for (int i = 0; i < 4; i++) t[i] = 11'sd220;
        repeat (2) @(posedge clk);
        #1;
        check_all_idle("reset");
        arst_n = 1'b1;
        tick();

        // Persistence on ch0
        feed(0, 11'sd170, 5);
        feed(0, 11'sd200, 1);
        check("pers_5_then_200", 32'(alerta), 32'h0);
        feed(0, 11'sd170, 5);
        check("pers_5th_cold", 32'(alerta), 32'h0);
        feed(0, 11'sd170, 1);
        check("pers_6th_alerta", 32'(alerta), 32'h1);
        check("pers_6th_calef", 32'(calefactor), 32'h1);
        check("pers_6th_estado", 32'(estado_actual), 32'h01);
        feed(0, 11'sd200, 1);
        check("pers_exit", 32'(estado_actual), 32'h00);

        // Valid gating on ch1
        feed(1, 11'sd300, 4);
        t[1] = 11'sd200;
        repeat (3) tick();
        check("gate_idle", 32'(alerta), 32'h0);
        feed(1, 11'sd300, 1);
        check("gate_5th", 32'(alerta), 32'h0);
        feed(1, 11'sd300, 1);
        check("gate_vent", 32'(ventilador), 32'h2);
        check("gate_estado", 32'(estado_actual), 32'h08);
        check("gate_glob_idx", 32'({alerta_global, canal_alerta_idx}), 32'h5);
        feed(1, 11'sd220, 1);

        // Boundaries on ch0
        feed(0, 11'sd180, 10);
        feed(0, 11'sd259, 10);
        check("bound_normal", 32'(alerta), 32'h0);
        feed(0, 11'sd179, 6);
        check("bound_179_frio", 32'(estado_actual), 32'h01);
        feed(0, 11'sd260, 1);
        check("bound_260_first", 32'(estado_actual), 32'h00);
        feed(0, 11'sd260, 5);
        check("bound_260_calor", 32'(estado_actual), 32'h02);
        check("bound_260_act", 32'({ventilador, calefactor}), 32'h10);
        feed(0, 11'sd220, 1);

        // Aggregation: ch3 then ch1
        feed(3, 11'sd300, 6);
        check("agg_ch3", 32'({alerta_global, canal_alerta_idx}), 32'h7);
        feed(1, 11'sd300, 6);
        check("agg_alerta", 32'(alerta), 32'hA);
        check("agg_ch1", 32'({alerta_global, canal_alerta_idx}), 32'h5);
        t[1] = 11'sd220;
        t[3] = 11'sd220;
        v    = 4'b1010;
        tick();
        v    = '0;
        check("agg_clear", 32'({alerta_global, canal_alerta_idx}), 32'h0);

        // Asynchronous reset mid-CALOR on ch2
        feed(2, 11'sd300, 6);
        check("rst_pre_calor", 32'(estado_actual), 32'h20);
        #2;
        arst_n = 1'b0;
        #1;
        check_all_idle("rst_mid");
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        feed(2, 11'sd300, 5);
        check("rst_5_hot", 32'(alerta), 32'h0);
        feed(2, 11'sd300, 1);
        check("rst_6_hot", 32'(estado_actual), 32'h20);
        feed(2, 11'sd220, 1);

        // Exit hysteresis on ch0
        feed(0, 11'sd170, 6);
        check("hyst_frio", 32'(estado_actual), 32'h01);
        feed(0, 11'sd185, 1);
`ifdef MON_HISTERESIS_EN
        check("hyst_185_hold", 32'(estado_actual), 32'h01);
        feed(0, 11'sd190, 1);
        check("hyst_190_exit", 32'(estado_actual), 32'h00);
`else
        check("nohyst_185_exit", 32'(estado_actual), 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
